// File: rtl/rv_data_in_bfm.sv
// Ready/valid sink BFM: accepts beats with a programmable post-accept hold-off, queues them in a small FIFO.
// Latency: accepted beat visible on rx_valid/rx_data one cycle after its acceptance edge (if FIFO was empty).
// Backpressure: data_ready drops during hold-off or when the FIFO is full; drained via rx_valid/rx_ack.
module rv_data_in_bfm #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [7:0]            ready_delay,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic [31:0]           rx_count,
  output logic                  protocol_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_ACCEPT, ST_HOLDOFF} state_t;

  state_t                r_state;
  logic [7:0]            r_hold_cnt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_fifo_count;
  logic [31:0]           r_rx_count;
  logic                  r_protocol_err;
  logic [DATA_WIDTH-1:0] r_prev_data;
  logic                  r_prev_valid;
  logic                  r_prev_ready;

  logic w_push;
  logic w_pop;
  logic w_violation;

  // Ready depends only on registered state (plus reset), never on data_valid.
  assign data_ready   = !reset && (r_state == ST_ACCEPT) && (r_fifo_count != FULL_CNT);
  assign w_push       = data_valid && data_ready;
  assign rx_valid     = (r_fifo_count != '0);
  assign w_pop        = rx_valid && rx_ack;
  assign rx_data      = r_mem[r_rd_ptr];
  assign rx_count     = r_rx_count;
  assign protocol_err = r_protocol_err;

  // A stalled beat must be held: valid may not drop and payload may not change.
  assign w_violation  = r_prev_valid && !r_prev_ready &&
                        (!data_valid || (data != r_prev_data));

  // Hold-off FSM: after an accept, keep ready low for exactly ready_delay cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_ACCEPT;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_push && (ready_delay != 8'd0)) begin
            r_state    <= ST_HOLDOFF;
            r_hold_cnt <= ready_delay;
          end
        end
        ST_HOLDOFF: begin
          r_hold_cnt <= r_hold_cnt - 8'd1;
          if (r_hold_cnt == 8'd1) begin
            r_state <= ST_ACCEPT;
          end
        end
        default: begin
          r_state    <= ST_ACCEPT;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO storage; cleared on reset so an empty FIFO presents zero on rx_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + (AW+1)'(1);
        2'b01:   r_fifo_count <= r_fifo_count - (AW+1)'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Accepted-beat counter, modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_count <= '0;
    end else if (w_push) begin
      r_rx_count <= r_rx_count + 32'd1;
    end
  end

  // Previous-cycle snapshot and sticky protocol violation flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_data    <= '0;
      r_prev_valid   <= 1'b0;
      r_prev_ready   <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_prev_data  <= data;
      r_prev_valid <= data_valid;
      r_prev_ready <= data_ready;
      if (w_violation) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_data_in_bfm.sv
// Directed bench for rv_data_in_bfm: reset, streaming, hold-off, FIFO full, protocol errors, wrap.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// Expected values come from hand-computed constants and tables.
module tb_rv_data_in_bfm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  ready_delay;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic [31:0] rx_count;
  logic        protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  // Hold-off table: ready_delay driven in each cycle and the expected data_ready.
  int rd_tab  [11] = '{3, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0};
  int rdy_tab [11] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1};

  always #5 clock = ~clock;

  rv_data_in_bfm #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .ready_delay  (ready_delay),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_count     (rx_count),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench at a falling edge with reset just released and inputs idle.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; data_valid = 1'b0; rx_ack = 1'b0; ready_delay = 8'd0; data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] beat;
    reset = 1'b1; data = '0; data_valid = 1'b0; ready_delay = 8'd0; rx_ack = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    data_valid = 1'b1; data = 32'hDEAD_0000;
    #1;
    check("rst_rdy",   {31'd0, data_ready},   32'd0);
    check("rst_vld",   {31'd0, rx_valid},     32'd0);
    check("rst_cnt",   rx_count,              32'd0);
    check("rst_perr",  {31'd0, protocol_err}, 32'd0);
    check("rst_dat",   rx_data,               32'd0);
    @(negedge clock);
    check("rst_noacc", {31'd0, rx_valid},     32'd0);

    // First beat after reset
    do_reset();
    data_valid = 1'b1; data = 32'hA5A5_0001;
    #1 check("t1_rdy", {31'd0, data_ready}, 32'd1);
    @(negedge clock);
    data_valid = 1'b0;
    check("t1_vld", {31'd0, rx_valid}, 32'd1);
    check("t1_dat", rx_data,           32'hA5A5_0001);
    check("t1_cnt", rx_count,          32'd1);

    // Stream 8 beats back to back with rx_ack held high
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      data = i; data_valid = 1'b1; rx_ack = 1'b1;
      #1 check("s_rdy", {31'd0, data_ready}, 32'd1);
      if (i > 0) check("s_dat", rx_data, i - 1);
    end
    @(negedge clock);
    data_valid = 1'b0;
    check("s_last", rx_data, 32'd7);
    @(negedge clock);
    rx_ack = 1'b0;
    check("s_empty", {31'd0, rx_valid},     32'd0);
    check("s_cnt",   rx_count,              32'd8);
    check("s_perr",  {31'd0, protocol_err}, 32'd0);

    // Programmable hold-off; delay sampled only at acceptance edges
    do_reset();
    beat = 32'd100;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      ready_delay = 8'(rd_tab[c]); data = beat; data_valid = 1'b1; rx_ack = 1'b1;
      #1 check("h_rdy", {31'd0, data_ready}, 32'(rdy_tab[c]));
      if (rdy_tab[c] != 0) beat = beat + 32'd1;
    end
    @(negedge clock);
    data_valid = 1'b0; ready_delay = 8'd0;
    check("h_cnt",  rx_count,              32'd5);
    check("h_perr", {31'd0, protocol_err}, 32'd0);

    // FIFO full backpressure
    do_reset();
    rx_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      data = k; data_valid = 1'b1;
      #1 check("f_rdy", {31'd0, data_ready}, 32'd1);
    end
    @(negedge clock);
    data = 32'd4;
    #1 check("f_full_rdy", {31'd0, data_ready}, 32'd0);
    @(negedge clock);
    #1 check("f_full_rdy2", {31'd0, data_ready}, 32'd0);
    @(negedge clock);
    rx_ack = 1'b1;
    #1 check("f_pop_rdy", {31'd0, data_ready}, 32'd0);
    check("f_pop0", rx_data, 32'd0);
    @(negedge clock);
    rx_ack = 1'b0;
    #1 check("f_reopen", {31'd0, data_ready}, 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      data_valid = 1'b0; rx_ack = 1'b1;
      #1 check("f_pop", rx_data, k);
    end
    @(negedge clock);
    rx_ack = 1'b0;
    check("f_empty", {31'd0, rx_valid}, 32'd0);
    check("f_cnt",   rx_count,          32'd5);

    // Valid withdrawn while stalled
    do_reset();
    data = 32'd9; data_valid = 1'b1; ready_delay = 8'd3;
    @(negedge clock);
    data = 32'd1; ready_delay = 8'd0;
    @(negedge clock);
    data_valid = 1'b0;
    check("pv_pre", {31'd0, protocol_err}, 32'd0);
    @(negedge clock);
    check("pv_set", {31'd0, protocol_err}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("pv_sticky", {31'd0, protocol_err}, 32'd1);

    // Payload changed while stalled
    do_reset();
    data = 32'd9; data_valid = 1'b1; ready_delay = 8'd3;
    @(negedge clock);
    data = 32'd1; ready_delay = 8'd0;
    @(negedge clock);
    data = 32'd2;
    check("pd_pre", {31'd0, protocol_err}, 32'd0);
    @(negedge clock);
    data_valid = 1'b0;
    check("pd_set", {31'd0, protocol_err}, 32'd1);

    // Reset during hold-off with 3 beats queued
    do_reset();
    data = 32'd10; data_valid = 1'b1;
    @(negedge clock);
    data = 32'd11;
    @(negedge clock);
    data = 32'd12; ready_delay = 8'd5;
    @(negedge clock);
    data_valid = 1'b0; ready_delay = 8'd0;
    #1 check("r_hold_rdy", {31'd0, data_ready}, 32'd0);
    check("r_pre_cnt", rx_count, 32'd3);
    @(negedge clock);
    reset = 1'b1; data_valid = 1'b1; data = 32'd13;
    @(negedge clock);
    reset = 1'b0; data_valid = 1'b0;
    #1 check("r_rdy", {31'd0, data_ready}, 32'd1);
    check("r_vld",  {31'd0, rx_valid},     32'd0);
    check("r_cnt",  rx_count,              32'd0);
    check("r_perr", {31'd0, protocol_err}, 32'd0);
    check("r_dat",  rx_data,               32'd0);

    // rx_count wrap at 2^32
    @(negedge clock);
    dut.r_rx_count = 32'hFFFF_FFFF;
    data = 32'd77; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    check("w_cnt", rx_count, 32'd0);
    check("w_dat", rx_data,  32'd77);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
